// File: rtl/chain_return_checker.sv
// chain_return_checker: launches a toggle into an inverter chain, checks ordered settling and reports latency.
module chain_return_checker #(
  parameter int N_STAGES    = 5,
  parameter int CNT_W       = 8,
  parameter int TIMEOUT     = 200,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic                drive,
  input  logic [N_STAGES-1:0] taps,
  output logic                busy,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [CNT_W-1:0]    res_latency,
  output logic [2:0]          res_err
);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [HW-1:0] HLAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] HONE = HW'(1);
  localparam logic [N_STAGES-1:0] MONE = N_STAGES'(1);
  localparam logic [2:0] E_OK = 3'd0, E_TIMEOUT = 3'd1, E_ORDER = 3'd2, E_GLITCH = 3'd3, E_UNSETTLED = 3'd4;
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, HOLD, REPORT} state_t;
  state_t state, state_n;
  logic [N_STAGES-1:0] s1, s, e, m, st;
  logic [CNT_W-1:0] cnt;
  logic [HW-1:0] hcnt;
  logic glitch, order, tmo, done;
  logic [2:0] werr;
  // match is a prefix exactly when adding one clears every set bit
  always_comb begin
    for (int j = 0; j < N_STAGES; j++) e[j] = (j % 2 == 0) ? ~drive : drive;
    m = ~(s ^ e);
    done = &m;
    glitch = |(st & ~m);
    order = |(m & (m + MONE));
    tmo = !done && cnt >= TMO;
    werr = glitch ? E_GLITCH : order ? E_ORDER : tmo ? E_TIMEOUT : E_OK;
  end
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? LAUNCH : IDLE;
      LAUNCH:  state_n = done ? WAIT : REPORT;
      WAIT:    state_n = werr != E_OK ? REPORT : done ? HOLD : WAIT;
      HOLD:    state_n = (!done || hcnt == HLAST) ? REPORT : HOLD;
      REPORT:  state_n = (res_valid && res_ready) ? IDLE : REPORT;
      default: state_n = IDLE;
    endcase
  end
  always_comb busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (reset) begin
      {s1, s, st} <= '0;
      drive <= 1'b0;
      cnt <= '0;
      hcnt <= '0;
      res_valid <= 1'b0;
      res_latency <= '0;
      res_err <= E_OK;
    end else begin
      s1 <= taps;
      s <= s1;
      res_valid <= state == REPORT && !(res_valid && res_ready);
      case (state)
        LAUNCH: begin
          drive <= done ? ~drive : drive;
          cnt <= CNT_ONE;
          st <= '0;
          res_latency <= '0;
          res_err <= done ? E_OK : E_UNSETTLED;
        end
        WAIT: begin
          cnt <= &cnt ? cnt : cnt + CNT_ONE;
          st <= m;
          hcnt <= '0;
          res_latency <= cnt;
          res_err <= werr;
        end
        HOLD: begin
          hcnt <= hcnt + HONE;
          res_err <= done ? E_OK : E_GLITCH;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_chain_return_checker.sv
// tb_chain_return_checker: inverter-chain model with fault injection, scoreboarded result checks.
module tb_chain_return_checker;
  localparam int N = 5, CW = 8, TMO = 20, HOLD = 4, DLY = 3;
  logic clk = 0, reset = 1, start = 0, res_ready = 0;
  logic drive, busy, res_valid;
  logic [N-1:0] taps, raw, flip, ins;
  logic [CW-1:0] res_latency;
  logic [2:0] res_err;
  int checks = 0, errors = 0;
  typedef struct { int mode; int rdly; int err; int lo; int hi; bit flip; } row_t;
  typedef struct { int err; int lo; int hi; } exp_t;
  exp_t sb[$];
  row_t rows [7];
  logic [DLY-1:0] hist [N];
  bit init_done = 0;
  logic last_drive = 0;
  int mode = 0, k = 0, got_lat = 0, lat0 = 0;

  chain_return_checker #(.N_STAGES(N), .CNT_W(CW), .TIMEOUT(TMO), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .reset(reset), .start(start), .drive(drive), .taps(taps), .busy(busy),
    .res_valid(res_valid), .res_ready(res_ready), .res_latency(res_latency), .res_err(res_err)
  );

  always #5 clk = ~clk;

  // modes: 0 normal, 2 stage 3 early, 3 stage 1 pulse, 4 frozen chain, 5 stage 2 stuck wrong
  always_comb begin
    for (int j = 0; j < N; j++) raw[j] = hist[j][DLY-1];
    flip = '0;
    if (mode == 2 && k >= 4 && k <= 11) flip[3] = 1'b1;
    if (mode == 3 && k == 8) flip[1] = 1'b1;
    if (mode == 5) flip[2] = 1'b1;
  end
  assign taps = raw ^ flip;
  assign ins = {raw[N-2:0], drive};

  always @(negedge clk) begin
    k <= (drive != last_drive) ? 1 : k + 1;
    last_drive <= drive;
    init_done <= 1'b1;
    for (int j = 0; j < N; j++)
      if (!init_done) hist[j] <= (j % 2 == 0) ? '1 : '0;
      else if (mode != 4) hist[j] <= {hist[j][DLY-2:0], ~ins[j]};
  end

  task automatic ck(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    #2;
    if (res_valid && res_ready) begin
      if (sb.size() == 0) ck(1'b0, "unexpected_result", res_err, -1);
      else begin
        exp_t x;
        x = sb.pop_front();
        got_lat = res_latency;
        ck(res_err == x.err, "res_err", res_err, x.err);
        ck(res_latency >= x.lo && res_latency <= x.hi, "res_latency", res_latency, x.lo);
      end
    end
  end

  task automatic run(input row_t r);
    bit d0;
    int n;
    mode = r.mode;
    repeat (30) @(negedge clk);
    d0 = drive;
    res_ready = (r.rdly == 0);
    start = 1;
    sb.push_back('{r.err, r.lo, r.hi});
    @(negedge clk);
    start = 0;
    n = 0;
    while (!res_valid && n < 300) begin @(negedge clk); n++; end
    ck(res_valid, "res_valid_seen", res_valid, 1);
    if (res_valid && r.rdly > 0) begin
      for (int i = 0; i < r.rdly; i++) begin
        ck(res_valid && busy && res_err == r.err && res_latency >= r.lo && res_latency <= r.hi,
           "report_hold", res_err, r.err);
        start = i[0];
        @(negedge clk);
      end
      start = 1;
      res_ready = 1;
      @(negedge clk);
      start = 0;
    end
    n = 0;
    while (res_valid && n < 300) begin @(negedge clk); n++; end
    ck(!busy, "idle_after_handshake", busy, 0);
    repeat (3) @(negedge clk);
    ck(!busy && !res_valid, "no_queued_start", busy, 0);
    ck(drive == (d0 ^ r.flip), "drive_after_run", drive, d0 ^ r.flip);
    res_ready = 0;
    mode = 0;
  endtask

  initial begin
    bit seen;
    rows[0] = '{0, 0, 0, 16, 18, 1'b1};
    rows[1] = '{0, 0, 0, 16, 18, 1'b1};
    rows[2] = '{2, 0, 2, 6, 6, 1'b1};
    rows[3] = '{3, 0, 3, 10, 10, 1'b1};
    rows[4] = '{4, 0, 1, 20, 20, 1'b1};
    rows[5] = '{5, 0, 4, 0, 0, 1'b0};
    rows[6] = '{0, 10, 0, 16, 18, 1'b1};
    repeat (3) @(negedge clk);
    ck(drive == 0, "reset_drive", drive, 0);
    ck(busy == 0, "reset_busy", busy, 0);
    ck(res_valid == 0, "reset_valid", res_valid, 0);
    ck(res_latency == 0, "reset_latency", res_latency, 0);
    ck(res_err == 0, "reset_err", res_err, 0);
    reset = 0;
    for (int i = 0; i < 7; i++) begin
      run(rows[i]);
      if (i == 0) lat0 = got_lat;
      if (i == 1) ck(got_lat >= lat0 - 1 && got_lat <= lat0 + 1, "falling_vs_rising_latency", got_lat, lat0);
    end
    repeat (30) @(negedge clk);
    res_ready = 1;
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (5) @(negedge clk);
    ck(drive == 1 && busy, "launched_before_reset", drive, 1);
    reset = 1;
    @(negedge clk);
    reset = 0;
    ck(drive == 0, "midrun_reset_drive", drive, 0);
    ck(busy == 0, "midrun_reset_busy", busy, 0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      seen |= res_valid | busy;
      @(negedge clk);
    end
    ck(!seen, "no_result_after_reset", seen, 0);
    res_ready = 0;
    run(rows[0]);
    ck(sb.size() == 0, "scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
